// File: rtl/dyt_pkg.sv
// Shared widths and the writeback-source select for the writeback unit.
// No logic; pure type/constant definitions.
// No backpressure; consumers decide their own flow control.
package dyt_pkg;

  localparam int ADDR_WIDTH = 4;
  localparam int DATA_WIDTH = 32;
  localparam int NUM_WORDS  = 2**ADDR_WIDTH;

  // Which producer owns the write port on a given edge.
  typedef enum logic [1:0] {
    WB_NONE = 2'd0,
    WB_ALU  = 2'd1,
    WB_LSU  = 2'd2
  } wb_src_t;

endpackage

// File: rtl/dyt_writeback_unit_if.sv
// Bundles the ALU/LSU result, load-issue, write-port and read-port signals.
// Wires only, zero latency.
// LSU side uses valid/ready; ALU and issue are push-only.
interface dyt_writeback_unit_if #(
  parameter int AW = dyt_pkg::ADDR_WIDTH,
  parameter int DW = dyt_pkg::DATA_WIDTH
) ();

  logic              alu_valid;
  logic [AW-1:0]     alu_rd;
  logic [DW-1:0]     alu_data;
  logic              lsu_valid;
  logic              lsu_ready;
  logic [AW-1:0]     lsu_rd;
  logic [DW-1:0]     lsu_data;
  logic              iss_ld_valid;
  logic [AW-1:0]     iss_ld_rd;
  logic [2**AW-1:0]  busy;
  logic              err;
  logic              w_en;
  logic [AW-1:0]     w_addr;
  logic [DW-1:0]     w_data;
  logic [AW-1:0]     r_a_addr;
  logic [AW-1:0]     r_b_addr;
  logic [DW-1:0]     r_a_rf_data;
  logic [DW-1:0]     r_b_rf_data;
  logic [DW-1:0]     r_a_data;
  logic [DW-1:0]     r_b_data;

  // Environment side: drives results, issues and read addresses.
  modport master (
    output alu_valid, alu_rd, alu_data,
    output lsu_valid, lsu_rd, lsu_data,
    output iss_ld_valid, iss_ld_rd,
    output r_a_addr, r_b_addr, r_a_rf_data, r_b_rf_data,
    input  lsu_ready, busy, err, w_en, w_addr, w_data, r_a_data, r_b_data
  );

  // Writeback unit side.
  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  lsu_valid, lsu_rd, lsu_data,
    input  iss_ld_valid, iss_ld_rd,
    input  r_a_addr, r_b_addr, r_a_rf_data, r_b_rf_data,
    output lsu_ready, busy, err, w_en, w_addr, w_data, r_a_data, r_b_data
  );

endinterface

// File: rtl/dyt_wb_scoreboard.sv
// Outstanding-load scoreboard with sticky protocol-error detection.
// busy/err update one edge after the triggering event.
// No backpressure; observes issue, LSU acceptance and ALU traffic only.
module dyt_wb_scoreboard #(
  parameter int ADDR_WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_iss_vld,
  input  logic [ADDR_WIDTH-1:0]    i_iss_rd,
  input  logic                     i_clr_vld,
  input  logic [ADDR_WIDTH-1:0]    i_clr_rd,
  input  logic                     i_alu_vld,
  input  logic [ADDR_WIDTH-1:0]    i_alu_rd,
  output logic [2**ADDR_WIDTH-1:0] o_busy,
  output logic                     o_err
);

  localparam int NW = 2**ADDR_WIDTH;

  logic [NW-1:0] r_busy;
  logic          r_err;
  logic [NW-1:0] w_set;
  logic [NW-1:0] w_clr;
  logic          w_err_hit;

  // Decode set/clear masks (x0 never tracked) and the three error conditions.
  always_comb begin
    w_set = '0;
    w_clr = '0;
    if (i_iss_vld) w_set[i_iss_rd] = 1'b1;
    if (i_clr_vld) w_clr[i_clr_rd] = 1'b1;
    w_set[0] = 1'b0;
    w_clr[0] = 1'b0;
    w_err_hit = (i_clr_vld && !r_busy[i_clr_rd]) ||
                (i_iss_vld && r_busy[i_iss_rd] && !w_clr[i_iss_rd]) ||
                (i_alu_vld && r_busy[i_alu_rd]);
  end

  // Set is applied after clear so a younger load to the same register wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_busy <= '0;
      r_err  <= 1'b0;
    end else begin
      r_busy <= (r_busy & ~w_clr) | w_set;
      r_err  <= r_err | w_err_hit;
    end
  end

  assign o_busy = r_busy;
  assign o_err  = r_err;

endmodule

// File: rtl/dyt_writeback_unit.sv
// Arbitrates ALU/LSU results onto the register-file write port and bypasses it to reads.
// One cycle from acceptance to w_en; bypass and lsu_ready are combinational.
// ALU has fixed priority; LSU is held off (lsu_ready low) whenever alu_valid is high.
module dyt_writeback_unit #(
  parameter int ADDR_WIDTH = dyt_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = dyt_pkg::DATA_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  dyt_writeback_unit_if.slave  bus
);

  import dyt_pkg::*;

  wb_src_t                 w_src;
  logic                    w_lsu_acc;
  logic                    r_w_en;
  logic [ADDR_WIDTH-1:0]   r_w_addr;
  logic [DATA_WIDTH-1:0]   r_w_data;

  assign bus.lsu_ready = rst & ~bus.alu_valid;
  assign w_lsu_acc     = bus.lsu_valid & bus.lsu_ready;

  // Fixed-priority select: ALU first, then an accepted LSU result.
  always_comb begin
    w_src = WB_NONE;
    if (bus.alu_valid)  w_src = WB_ALU;
    else if (w_lsu_acc) w_src = WB_LSU;
  end

  // Single write-stage register; addr/data hold when nothing is taken.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_w_en   <= 1'b0;
      r_w_addr <= '0;
      r_w_data <= '0;
    end else begin
      case (w_src)
        WB_ALU: begin
          r_w_en   <= (bus.alu_rd != '0);
          r_w_addr <= bus.alu_rd;
          r_w_data <= bus.alu_data;
        end
        WB_LSU: begin
          r_w_en   <= (bus.lsu_rd != '0);
          r_w_addr <= bus.lsu_rd;
          r_w_data <= bus.lsu_data;
        end
        default: r_w_en <= 1'b0;
      endcase
    end
  end

  assign bus.w_en   = r_w_en;
  assign bus.w_addr = r_w_addr;
  assign bus.w_data = r_w_data;

  // The staged write is newer than the register file; x0 always reads the file.
  assign bus.r_a_data = (r_w_en && (r_w_addr == bus.r_a_addr) && (bus.r_a_addr != '0))
                        ? r_w_data : bus.r_a_rf_data;
  assign bus.r_b_data = (r_w_en && (r_w_addr == bus.r_b_addr) && (bus.r_b_addr != '0))
                        ? r_w_data : bus.r_b_rf_data;

  dyt_wb_scoreboard #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .i_iss_vld (bus.iss_ld_valid),
    .i_iss_rd  (bus.iss_ld_rd),
    .i_clr_vld (w_lsu_acc),
    .i_clr_rd  (bus.lsu_rd),
    .i_alu_vld (bus.alu_valid),
    .i_alu_rd  (bus.alu_rd),
    .o_busy    (bus.busy),
    .o_err     (bus.err)
  );

endmodule

// File: tb/tb_dyt_writeback_unit.sv
// Scoreboard bench: driver pushes per-cycle expectations from an architectural model.
// Monitor pops one expectation each negedge and compares all visible outputs.
// LSU agent holds its offer stable until accepted.
module tb_dyt_writeback_unit;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  dyt_writeback_unit_if bus ();

  dyt_writeback_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Register file seen by the unit: commits on w_en, x0 hard-wired to zero.
  logic [31:0] rf [16] = '{default: 32'h0};
  always @(posedge clk) if (bus.w_en === 1'b1 && bus.w_addr != 4'd0) rf[bus.w_addr] <= bus.w_data;
  assign bus.r_a_rf_data = rf[bus.r_a_addr];
  assign bus.r_b_rf_data = rf[bus.r_b_addr];

  typedef struct {
    logic        rdy;
    logic [31:0] ra;
    logic [31:0] rb;
    logic        wen;
    logic [3:0]  waddr;
    logic [31:0] wdata;
    logic [15:0] busy;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  // Architectural model: committed registers plus the one write in flight.
  logic        m_wen = 1'b0;
  logic [3:0]  m_waddr = 4'd0;
  logic [31:0] m_wdata = 32'h0;
  logic [15:0] m_busy = 16'h0;
  logic        m_err = 1'b0;
  logic [31:0] m_rf [16] = '{default: 32'h0};
  int          lq[$];
  logic        hold = 1'b0;
  logic [3:0]  hold_rd = 4'd0;
  logic [31:0] hold_d = 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, want, $time);
    end
  endtask

  // Newest architectural value of a register as decode should see it.
  function automatic logic [31:0] view(input logic [3:0] a);
    if (a == 4'd0) return 32'h0;
    if (m_wen && m_waddr == a) return m_wdata;
    return m_rf[a];
  endfunction

  always @(negedge clk) begin : mon
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("lsu_ready", {31'h0, bus.lsu_ready}, {31'h0, e.rdy});
      chk("r_a_data",  bus.r_a_data, e.ra);
      chk("r_b_data",  bus.r_b_data, e.rb);
      chk("w_en",      {31'h0, bus.w_en}, {31'h0, e.wen});
      chk("w_addr",    {28'h0, bus.w_addr}, {28'h0, e.waddr});
      chk("w_data",    bus.w_data, e.wdata);
      chk("busy",      {16'h0, bus.busy}, {16'h0, e.busy});
      chk("err",       {31'h0, bus.err}, {31'h0, e.err});
    end
  end

  // One clock cycle: drive inputs, record expectation, advance the model.
  task automatic cyc(input logic av, input logic [3:0] ard, input logic [31:0] ad,
                     input logic lv, input logic [3:0] lrd, input logic [31:0] ld,
                     input logic iv, input logic [3:0] ird,
                     input logic [3:0] ra, input logic [3:0] rb, output logic acc);
    exp_t e;
    logic rdy;
    bus.alu_valid = av;  bus.alu_rd = ard;  bus.alu_data = ad;
    bus.lsu_valid = lv;  bus.lsu_rd = lrd;  bus.lsu_data = ld;
    bus.iss_ld_valid = iv;  bus.iss_ld_rd = ird;
    bus.r_a_addr = ra;  bus.r_b_addr = rb;
    rdy = !av;
    e.rdy = rdy;  e.ra = view(ra);  e.rb = view(rb);
    e.wen = m_wen;  e.waddr = m_waddr;  e.wdata = m_wdata;
    e.busy = m_busy;  e.err = m_err;
    exp_q.push_back(e);
    acc = lv && rdy;
    if (acc && !m_busy[lrd]) m_err = 1'b1;
    if (iv && m_busy[ird] && !(acc && lrd == ird)) m_err = 1'b1;
    if (av && m_busy[ard]) m_err = 1'b1;
    if (m_wen) m_rf[m_waddr] = m_wdata;
    if (av) begin
      m_wen = (ard != 4'd0);  m_waddr = ard;  m_wdata = ad;
    end else if (acc) begin
      m_wen = (lrd != 4'd0);  m_waddr = lrd;  m_wdata = ld;
    end else begin
      m_wen = 1'b0;
    end
    if (acc && lrd != 4'd0) begin
      m_busy[lrd] = 1'b0;
      for (int i = 0; i < lq.size(); i++) if (lq[i] == int'(lrd)) begin lq.delete(i); break; end
    end
    if (iv && ird != 4'd0) begin
      if (!m_busy[ird]) lq.push_back(int'(ird));
      m_busy[ird] = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic [3:0] ra, input logic [3:0] rb);
    logic acc;
    cyc(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, ra, rb, acc);
  endtask

  // Two cycles in reset; the in-flight write and all loads are dropped.
  task automatic reset_dut(input logic [3:0] ra, input logic [3:0] rb);
    exp_t e;
    rst = 1'b0;
    bus.alu_valid = 1'b0;  bus.lsu_valid = 1'b0;  bus.iss_ld_valid = 1'b0;
    bus.r_a_addr = ra;  bus.r_b_addr = rb;
    m_wen = 1'b0;  m_waddr = 4'd0;  m_wdata = 32'h0;
    m_busy = 16'h0;  m_err = 1'b0;  lq.delete();  hold = 1'b0;
    for (int k = 0; k < 2; k++) begin
      e.rdy = 1'b0;  e.ra = view(ra);  e.rb = view(rb);
      e.wen = 1'b0;  e.waddr = 4'd0;  e.wdata = 32'h0;  e.busy = 16'h0;  e.err = 1'b0;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
  endtask

  task automatic rand_cycle();
    logic av, iv, acc, pacc;
    logic [3:0] ard, ird;
    if (!hold && lq.size() > 0 && ($urandom % 3) != 0) begin
      hold = 1'b1;  hold_rd = 4'(lq[0]);  hold_d = $urandom;
    end
    av  = ($urandom % 2) == 1;
    ard = 4'($urandom % 16);
    if (m_busy[ard]) ard = 4'd0;
    pacc = hold && !av;
    iv  = ($urandom % 4) == 0;
    ird = 4'($urandom_range(15, 1));
    if (m_busy[ird] && !(pacc && hold_rd == ird)) iv = 1'b0;
    cyc(av, ard, $urandom, hold, hold_rd, hold_d, iv, ird,
        4'($urandom % 16), 4'($urandom % 16), acc);
    if (acc) hold = 1'b0;
  endtask

  initial begin
    logic acc;
    bus.alu_valid = 1'b0;  bus.alu_rd = 4'd0;  bus.alu_data = 32'h0;
    bus.lsu_valid = 1'b0;  bus.lsu_rd = 4'd0;  bus.lsu_data = 32'h0;
    bus.iss_ld_valid = 1'b0;  bus.iss_ld_rd = 4'd0;
    bus.r_a_addr = 4'd0;  bus.r_b_addr = 4'd0;
    @(posedge clk);
    #1;
    reset_dut(4'd0, 4'd0);
    idle(4'd0, 4'd0);
    // ALU write and bypass of x3
    cyc(1'b1, 4'd3, 32'hDEADBEEF, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 4'd0, 4'd0, acc);
    idle(4'd3, 4'd0);
    idle(4'd3, 4'd3);
    // ALU beats a simultaneous LSU result; LSU holds and follows
    cyc(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0, 1'b1, 4'd6, 4'd0, 4'd0, acc);
    cyc(1'b1, 4'd5, 32'hA5A5A5A5, 1'b1, 4'd6, 32'h0BADF00D, 1'b0, 4'd0, 4'd6, 4'd0, acc);
    cyc(1'b0, 4'd0, 32'h0, 1'b1, 4'd6, 32'h0BADF00D, 1'b0, 4'd0, 4'd5, 4'd6, acc);
    idle(4'd6, 4'd5);
    // load to x7 round trip
    cyc(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0, 1'b1, 4'd7, 4'd0, 4'd0, acc);
    idle(4'd7, 4'd0);
    cyc(1'b0, 4'd0, 32'h0, 1'b1, 4'd7, 32'h12345678, 1'b0, 4'd0, 4'd7, 4'd0, acc);
    idle(4'd7, 4'd0);
    idle(4'd7, 4'd7);
    // writes to x0 never reach the register file
    cyc(1'b1, 4'd0, 32'hFFFFFFFF, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 4'd0, 4'd0, acc);
    idle(4'd0, 4'd0);
    // return and re-issue of x9 on the same edge
    cyc(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0, 1'b1, 4'd9, 4'd0, 4'd0, acc);
    cyc(1'b0, 4'd0, 32'h0, 1'b1, 4'd9, 32'h00009999, 1'b1, 4'd9, 4'd9, 4'd0, acc);
    idle(4'd9, 4'd9);
    cyc(1'b0, 4'd0, 32'h0, 1'b1, 4'd9, 32'h99990000, 1'b0, 4'd0, 4'd9, 4'd0, acc);
    idle(4'd9, 4'd0);
    // randomized legal traffic
    for (int n = 0; n < 1500; n++) rand_cycle();
    for (int n = 0; n < 64 && (lq.size() > 0 || hold); n++) begin
      if (!hold) begin hold = 1'b1;  hold_rd = 4'(lq[0]);  hold_d = $urandom; end
      cyc(1'b0, 4'd0, 32'h0, 1'b1, hold_rd, hold_d, 1'b0, 4'd0, hold_rd, 4'd0, acc);
      if (acc) hold = 1'b0;
    end
    chk("lsu_drained", 32'(lq.size()), 32'd0);
    // reset while a write is staged and x1/x7 are busy
    cyc(1'b1, 4'd2, 32'h22222222, 1'b0, 4'd0, 32'h0, 1'b1, 4'd1, 4'd0, 4'd0, acc);
    cyc(1'b1, 4'd3, 32'h33333333, 1'b0, 4'd0, 32'h0, 1'b1, 4'd7, 4'd2, 4'd0, acc);
    reset_dut(4'd3, 4'd2);
    idle(4'd3, 4'd2);
    idle(4'd3, 4'd2);
    // return to a non-busy register sets the sticky error
    cyc(1'b0, 4'd0, 32'h0, 1'b1, 4'd4, 32'h44444444, 1'b0, 4'd0, 4'd4, 4'd0, acc);
    idle(4'd4, 4'd0);
    idle(4'd4, 4'd3);
    idle(4'd0, 4'd0);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
